// File: rtl/mskaes_kexp_pkg.sv
// Shared definitions for the masked AES key-expansion engine.
//
// Share encoding (bit-sliced): within a byte field of 8*d bits, bit j of
// share s lives at index d*j + s. Byte b of a word or key sits at
// [8*d*b +: 8*d], byte 0 being the first FIPS-197 byte.
package mskaes_kexp_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_RSVD = 2'd3
  } kexp_keylen_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_SB_REQ,
    ST_SB_WAIT,
    ST_DONE
  } kexp_state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [5:0] LAST_128 = 6'd43;
  localparam logic [5:0] LAST_192 = 6'd51;
  localparam logic [5:0] LAST_256 = 6'd59;

  localparam logic [7:0] XTIME_POLY = 8'h1b;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NK_192;
      KL_256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic logic [5:0] last_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return LAST_192;
      KL_256:  return LAST_256;
      default: return LAST_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mskaes_kexp_window.sv
// Sliding window of the last Nk shared key words.
//
// Ports:
//   clk      clock (window is not reset; content is don't-care until load)
//   load     capture all 8 key words from sh_key
//   shift    drop the oldest word and append shift_in at slot Nk-1
//   nk       runtime Nk (4/6/8)
//   sh_key   shared key, word k at [32*d*k +: 32*d]
//   shift_in newly computed word w[i]
//   rd_idx   direct read index (used while i < Nk)
//   rd_word  window[rd_idx]
//   w_old    w[i-Nk] tap (slot 0)
//   w_prev   w[i-1]  tap (slot Nk-1)
module mskaes_kexp_window
  import mskaes_kexp_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [3:0]        nk,
  input  logic [256*d-1:0]  sh_key,
  input  logic [32*d-1:0]   shift_in,
  input  logic [2:0]        rd_idx,
  output logic [32*d-1:0]   rd_word,
  output logic [32*d-1:0]   w_old,
  output logic [32*d-1:0]   w_prev
);

  localparam int unsigned W = 32 * d;

  logic [W-1:0] win_q [8];

  // Slot 0 is always the oldest live word; the newest sits at slot Nk-1.
  // Slots above Nk-1 carry junk and are never selected by the taps.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned j = 0; j < 8; j++) begin
        win_q[j] <= sh_key[W*j +: W];
      end
    end else if (shift) begin
      for (int unsigned j = 0; j < 7; j++) begin
        win_q[j] <= (j + 1 == 32'(nk)) ? shift_in : win_q[j+1];
      end
      win_q[7] <= shift_in;
    end
  end

  always_comb begin
    case (nk)
      NK_192:  w_prev = win_q[5];
      NK_256:  w_prev = win_q[7];
      default: w_prev = win_q[3];
    endcase
  end

  assign w_old   = win_q[0];
  assign rd_word = win_q[rd_idx];

endmodule

// File: rtl/mskaes_key_expansion_multi.sv
// Masked (d-share) AES-128/192/256 key expansion, one shared 32-bit word
// per out_valid/out_ready handshake. The S-box is borrowed through a
// fixed-latency request port (result SB_LAT cycles after sb_in_valid).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      key load request (accepted only in IDLE, key_len != 3)
//   in_ready      high in IDLE
//   key_len       0/1/2 = AES-128/192/256, 3 = reserved (ignored)
//   sh_key        shared key
//   abort         synchronous return to IDLE
//   sb_in_valid   one-cycle S-box request
//   sh_sb_in      word sent to the S-box
//   sh_sb_out     S-box result, valid SB_LAT cycles after the request
//   out_valid     sh_word valid
//   out_ready     consumer accepts
//   sh_word       expanded word w[i]
//   word_idx      i
//   out_last      high with the final word (43/51/59)
module mskaes_key_expansion_multi
  import mskaes_kexp_pkg::*;
#(
  parameter int unsigned d      = 2,
  parameter int unsigned SB_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        key_len,
  input  logic [256*d-1:0]  sh_key,
  input  logic              abort,
  output logic              sb_in_valid,
  output logic [32*d-1:0]   sh_sb_in,
  input  logic [32*d-1:0]   sh_sb_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*d-1:0]   sh_word,
  output logic [5:0]        word_idx,
  output logic              out_last
);

  localparam int unsigned W  = 32 * d;
  localparam int unsigned BW = 8 * d;
  localparam int unsigned CW = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;

  kexp_state_e   state_q, state_d;
  logic [1:0]    kl_q;
  logic [5:0]    idx_q;
  logic [2:0]    pos_q;     // i mod Nk
  logic [7:0]    rcon_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  sb_res_q;

  logic [3:0]    nk;
  logic [5:0]    last_idx;
  logic          load, hs, first_phase, cur_sbox, nx_sbox, sb_done;
  logic [3:0]    pos_inc;
  logic [2:0]    pos_nx;
  logic [5:0]    idx_nx;
  logic [W-1:0]  rd_word, w_old, w_prev, word_calc, sb_term;
  logic [BW-1:0] rcon_sh;

  assign nk       = nk_of(kl_q);
  assign last_idx = last_of(kl_q);

  assign load        = (state_q == ST_IDLE) && in_valid && !abort && (key_len != KL_RSVD);
  assign hs          = (state_q == ST_EMIT) && out_ready;
  assign first_phase = idx_q < {2'b00, nk};
  assign sb_done     = (state_q == ST_SB_WAIT) && (cnt_q == CW'(SB_LAT - 1));

  assign pos_inc = {1'b0, pos_q} + 4'd1;
  assign pos_nx  = (pos_inc == nk) ? 3'd0 : pos_inc[2:0];
  assign idx_nx  = idx_q + 6'd1;

  assign cur_sbox = !first_phase &&
                    ((pos_q == 3'd0) || ((nk == NK_256) && (pos_q == 3'd4)));
  assign nx_sbox  = (idx_nx >= {2'b00, nk}) &&
                    ((pos_nx == 3'd0) || ((nk == NK_256) && (pos_nx == 3'd4)));

  mskaes_kexp_window #(.d(d)) u_window (
    .clk      (clk),
    .load     (load),
    .shift    (hs && !first_phase),
    .nk       (nk),
    .sh_key   (sh_key),
    .shift_in (word_calc),
    .rd_idx   (idx_q[2:0]),
    .rd_word  (rd_word),
    .w_old    (w_old),
    .w_prev   (w_prev)
  );

  // Datapath: every operation below acts on each share independently.
  always_comb begin
    rcon_sh = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      rcon_sh[d*j] = rcon_q[j];   // share 0 of byte 0
    end
    sb_term = sb_res_q;
    if (pos_q == 3'd0) begin
      sb_term[BW-1:0] = sb_res_q[BW-1:0] ^ rcon_sh;
    end
    word_calc = w_old ^ (cur_sbox ? sb_term : w_prev);
    sh_word   = first_phase ? rd_word : word_calc;

    sh_sb_in = '0;
    if (state_q == ST_SB_REQ) begin
      // RotWord: byte 1 moves into byte 0, byte 0 wraps to byte 3.
      sh_sb_in = (pos_q == 3'd0) ? {w_prev[BW-1:0], w_prev[W-1:BW]} : w_prev;
    end
  end

  assign word_idx = idx_q;

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sb_in_valid = 1'b0;
    out_last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (load) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_last  = (idx_q == last_idx);
        if (out_ready) begin
          if (idx_q == last_idx) state_d = ST_DONE;
          else if (nx_sbox)      state_d = ST_SB_REQ;
        end
      end
      ST_SB_REQ: begin
        sb_in_valid = 1'b1;
        state_d     = ST_SB_WAIT;
      end
      ST_SB_WAIT: begin
        if (sb_done) state_d = ST_EMIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kl_q    <= 2'd0;
      idx_q   <= '0;
      pos_q   <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        rcon_q <= '0;
      end else if (load) begin
        kl_q   <= key_len;
        idx_q  <= '0;
        pos_q  <= '0;
        rcon_q <= 8'h01;
      end else if (hs) begin
        idx_q <= idx_nx;
        pos_q <= pos_nx;
        if (cur_sbox && (pos_q == 3'd0)) rcon_q <= xtime(rcon_q);
      end
      if (state_q == ST_SB_REQ)       cnt_q <= '0;
      else if (state_q == ST_SB_WAIT) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Shared data is not reset; only captured on the last wait cycle.
  always_ff @(posedge clk) begin
    if (sb_done) sb_res_q <= sh_sb_out;
  end

endmodule

// File: doc/mskaes_key_expansion_multi.md
Name: mskaes_key_expansion_multi

Overview:
- Masked (d-share) AES key-expansion engine for AES-128/192/256, selected per key load; emits the expanded key one 32-bit shared word per handshake.
- Holds a sliding window of the last Nk words.
- Borrows the shared masked S-box through a fixed-latency request port, with the S-box owning the randomness.
- Feeds the round-key adder of the 32-bit masked AES core.

Parameters:
- d, 2, number of shares (≥2).
- SB_LAT, 4, cycles from S-box request to result; ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  key load request.
- in_ready  out  1  high only in IDLE.
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled with the key.
- sh_key  in  256*d  shared key, codebase bit-sliced share encoding. Byte b is at [8*d*b +: 8*d], byte 0 = first FIPS byte. AES-128/192 use the low 16/24 bytes.
- abort  in  1  synchronous return to IDLE.
- sb_in_valid  out  1  one-cycle S-box request.
- sh_sb_in  out  32*d  word to S-box, same byte order.
- sh_sb_out  in  32*d  S-box result, valid exactly SB_LAT cycles after the request.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts.
- sh_word  out  32*d  expanded word w[i].
- word_idx  out  6  i.
- out_last  out  1  high with the final word (i = 43/51/59).

Behaviour:
- Reset (async) effects:
  - State goes to IDLE.
  - out_valid=0, sb_in_valid=0, out_last=0, word_idx=0; in_ready=1 once reset is released.
  - Counters and rcon are cleared.
  - Shared key/window registers are NOT reset; their content is don't-care until the next load.
- Load: in IDLE, in_valid & in_ready with key_len≠3 captures Nk=4/6/8 key words into the window, resets rcon to 0x01 and sets i=0.
  - key_len=3: request ignored, stay in IDLE.
- States:
  - IDLE: wait for load.
  - EMIT: present w[i].
  - SB_REQ: one cycle, sb_in_valid=1.
  - SB_WAIT: SB_LAT cycles.
  - DONE: one cycle, then back to IDLE.
- Words i<Nk come directly from the window. EMIT starts the cycle after load, so out_valid=1 in cycle 1 with w0.
- Words i≥Nk: w[i] = w[i−Nk] ⊕ temp.
  - i mod Nk = 0: sh_sb_in = RotWord(w[i−1]); temp = sh_sb_out ⊕ rcon. Rcon is added to share 0 only, byte 0. rcon advances by xtime after use.
  - Nk=8 and i mod 8 = 4: sh_sb_in = w[i−1] (no rotation); temp = sh_sb_out.
  - Otherwise temp = w[i−1]. The word is computed combinationally from the window and presented in EMIT.
- S-box words:
  - Handshake of w[i−1] in EMIT moves to SB_REQ (cycle T).
  - The result is registered at the SB_LAT-th edge after T.
  - out_valid rises in cycle T+SB_LAT+1.
- Non-S-box words: out_valid rises the cycle after the previous handshake.
- Window update: on handshake with i≥Nk, w[i] shifts in and the oldest word drops; i increments. For i<Nk only i increments.
- Output stability: while out_valid & !out_ready, sh_word, word_idx and out_last are held stable.
- Last word: handshake of the word with out_last=1 → DONE → IDLE. in_ready is high again 2 cycles after the last handshake.
- Abort:
  - Abort in any state → IDLE on the next edge. out_valid and sb_in_valid drop, rcon is cleared.
  - A pending S-box result is discarded and sh_sb_out is ignored while in IDLE.
  - If abort and in_valid arrive in the same IDLE cycle, abort wins and no load occurs.
- Masking:
  - All share-wise operations (XOR, rotation, mux) are share-local; no share recombination anywhere.
  - Unused window slots are not fed into sh_sb_in.

Decomposition:
- Shared package mskaes_kexp_pkg:
  - key_len encodings.
  - Nk table (4/6/8) and last-index table (43/51/59).
  - FSM state enum.
  - The xtime constant 0x1b.
- One sub-module: mskaes_kexp_window.
  - Holds the 8-word shared shift window.
  - Provides the w[i−Nk] and w[i−1] taps for a runtime Nk.
  - Handles load and shift.
- The FSM, rcon and output logic live in the top module.

Test Plan:
- AES-128, FIPS-197 key 2b7e1516…09cf4f3c, out_ready=1, SB_LAT=4 → w4=a0fafe17 valid in cycle 10; w43=b6630ca6 with out_last=1; 44 words in total.
- AES-192, key 8e73b0f7…522c6b7b → w6=fe0c91f7; w51=01002202 with out_last=1.
- AES-256, key 603deb10…0914dff4 → w8=9ba35411; w59=706c631e with out_last. The SB_REQ count must equal 13 (7 RotWord + 6 SubWord-only).
- Random out_ready backpressure, d=3, random share refresh in the S-box model → recombined words match the golden model; sh_word and word_idx stable while stalled.
- Abort during SB_WAIT, then a new AES-128 load → IDLE the next cycle, late S-box result ignored, new expansion correct from w0 (rcon restarts at 01).
- Async rst pulse mid-expansion → out_valid/sb_in_valid drop immediately; in_ready=1 after release; key_len=3 load is ignored with no output.
